duty_pwm_gen: RTL and testbench

- Converts a duty level of 0..8 into a PWM waveform. This is the generating end of the one-hot duty-level encoding used in the design.
- Each PWM period is WORD_LENGTH slots long. The output is high for the first N slots, where N is the active duty level.
- A prescaler sets the slot length. Duty updates arrive over a valid/ready handshake and take effect only at a period boundary, so the output never glitches mid-period.
- Also emits the current slot as a one-hot vector, bit k = slot k, in the same format the duty encoder consumes.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_prescaler.sv | 32 +++
 rtl/duty_pwm_gen.sv | 111 +++++++++++
 tb/tb_duty_pwm_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the one-hot duty-level PWM path.
// The clamp function is also used by the duty encoder.
package pwm_pkg;

    localparam int WORD_LENGTH    = 8;
    localparam int DUTY_WIDTH     = $clog2(WORD_LENGTH + 1);
    localparam int DUTY_MAX       = WORD_LENGTH;
    localparam int PRESCALE_WIDTH = 16;
    localparam int SLOT_WIDTH     = $clog2(WORD_LENGTH);

    typedef logic [DUTY_WIDTH-1:0]  duty_t;
    typedef logic [WORD_LENGTH-1:0] slot_onehot_t;
    typedef logic [SLOT_WIDTH-1:0]  slot_t;

    // Levels above a full period saturate instead of wrapping.
    function automatic duty_t clamp_duty(input duty_t duty);
        return (duty > duty_t'(DUTY_MAX)) ? duty_t'(DUTY_MAX) : duty;
    endfunction

    function automatic slot_onehot_t slot_to_onehot(input slot_t slot);
        slot_onehot_t onehot;
        onehot       = '0;
        onehot[slot] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Slot-length prescaler: tick marks the last clk cycle of every slot.
module pwm_prescaler #(
    parameter int PRESCALE_WIDTH = pwm_pkg::PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count_q;
    logic [PRESCALE_WIDTH-1:0] count_d;

    // A Prescale lowered below the running count lets the count wrap the full width.
    always_comb begin
        tick    = enable && (count_q == Prescale);
        count_d = count_q + PRESCALE_WIDTH'(1);
        if (!enable || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/duty_pwm_gen.sv
// PWM generator: duty level 0..WORD_LENGTH in, registered PWM plus one-hot slot out.
// Duty requests are double-buffered so a change lands only on a period boundary.
module duty_pwm_gen #(
    parameter int WORD_LENGTH    = pwm_pkg::WORD_LENGTH,
    parameter int DUTY_WIDTH     = pwm_pkg::DUTY_WIDTH,
    parameter int PRESCALE_WIDTH = pwm_pkg::PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [DUTY_WIDTH-1:0]     Duty_In,
    input  logic                      duty_valid,
    output logic                      duty_ready,
    output logic                      Pwm_Out,
    output logic [WORD_LENGTH-1:0]    Slot_OneHot,
    output logic                      period_done
);

    import pwm_pkg::clamp_duty;

    localparam int                    SLOT_WIDTH = $clog2(WORD_LENGTH);
    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT  = SLOT_WIDTH'(WORD_LENGTH - 1);

    logic                   tick;
    logic                   boundary;
    logic                   accept;
    logic                   transfer;

    logic [SLOT_WIDTH-1:0]  slot_q,          slot_d;
    logic [DUTY_WIDTH-1:0]  active_duty_q,   active_duty_d;
    logic [DUTY_WIDTH-1:0]  pending_duty_q,  pending_duty_d;
    logic                   pending_valid_q, pending_valid_d;
    logic                   pwm_q,           pwm_d;
    logic [WORD_LENGTH-1:0] onehot_q,        onehot_d;
    logic                   done_q,          done_d;

    pwm_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .Prescale (Prescale),
        .tick     (tick)
    );

    always_comb begin
        boundary = tick && (slot_q == LAST_SLOT);
        slot_d   = slot_q;
        if (!enable) begin
            slot_d = '0;
        end else if (tick) begin
            slot_d = boundary ? '0 : slot_q + SLOT_WIDTH'(1);
        end
    end

    // Accept and transfer are mutually exclusive since both key off pending_valid_q;
    // a request accepted in a boundary cycle therefore waits for the next boundary.
    always_comb begin
        duty_ready      = !pending_valid_q;
        accept          = duty_valid && !pending_valid_q;
        transfer        = pending_valid_q && (!enable || boundary);

        active_duty_d   = active_duty_q;
        pending_duty_d  = pending_duty_q;
        pending_valid_d = pending_valid_q;

        if (transfer) begin
            active_duty_d   = pending_duty_q;
            pending_valid_d = 1'b0;
        end
        if (accept) begin
            pending_duty_d  = clamp_duty(Duty_In);
            pending_valid_d = 1'b1;
        end
    end

    // Compare against next-state values so Pwm_Out and Slot_OneHot name the same slot.
    always_comb begin
        pwm_d            = enable && (DUTY_WIDTH'(slot_d) < active_duty_d);
        onehot_d         = '0;
        onehot_d[slot_d] = 1'b1;
        done_d           = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q          <= '0;
            active_duty_q   <= '0;
            pending_duty_q  <= '0;
            pending_valid_q <= 1'b0;
            pwm_q           <= 1'b0;
            onehot_q        <= WORD_LENGTH'(1);
            done_q          <= 1'b0;
        end else begin
            slot_q          <= slot_d;
            active_duty_q   <= active_duty_d;
            pending_duty_q  <= pending_duty_d;
            pending_valid_q <= pending_valid_d;
            pwm_q           <= pwm_d;
            onehot_q        <= onehot_d;
            done_q          <= done_d;
        end
    end

    assign Pwm_Out     = pwm_q;
    assign Slot_OneHot = onehot_q;
    assign period_done = done_q;

endmodule

// File: tb/tb_duty_pwm_gen.sv
// Bench for duty_pwm_gen: directed scenarios plus random traffic against a cycle model.
module tb_duty_pwm_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] Prescale;
    logic [3:0]  Duty_In;
    logic        duty_valid;
    logic        duty_ready;
    logic        Pwm_Out;
    logic [7:0]  Slot_OneHot;
    logic        period_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    duty_pwm_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .Prescale    (Prescale),
        .Duty_In     (Duty_In),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .Pwm_Out     (Pwm_Out),
        .Slot_OneHot (Slot_OneHot),
        .period_done (period_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: plain integers following the documented rules, updated per edge.
    bit m_init = 1'b0;
    int m_cnt, m_slot, m_active, m_pend;
    bit m_pv, m_pwm, m_done;

    always @(posedge clk) begin
        bit m_tick, m_bnd, m_acc, m_xfer;
        if (reset) begin
            m_init = 1'b1;
            m_cnt = 0; m_slot = 0; m_active = 0; m_pend = 0;
            m_pv = 1'b0; m_pwm = 1'b0; m_done = 1'b0;
        end else if (m_init) begin
            m_tick = enable && (m_cnt == int'(Prescale));
            m_bnd  = m_tick && (m_slot == 7);
            m_cnt  = (!enable || m_tick) ? 0 : (m_cnt + 1) % 65536;
            m_slot = !enable ? 0 : (m_tick ? (m_slot + 1) % 8 : m_slot);
            m_acc  = duty_valid && !m_pv;
            m_xfer = m_pv && (!enable || m_bnd);
            if (m_xfer) begin
                m_active = m_pend;
                m_pv     = 1'b0;
            end
            if (m_acc) begin
                m_pend = (int'(Duty_In) > 8) ? 8 : int'(Duty_In);
                m_pv   = 1'b1;
            end
            m_pwm  = enable && (m_slot < m_active);
            m_done = m_bnd;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("pwm_out",     32'(Pwm_Out),     32'(m_pwm));
            chk("slot_onehot", 32'(Slot_OneHot), 32'(1) << m_slot);
            chk("period_done", 32'(period_done), 32'(m_done));
            chk("duty_ready",  32'(duty_ready),  32'(!m_pv));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_duty(input int d);
        bit ok = 1'b0;
        Duty_In    = 4'(d);
        duty_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (duty_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_duty_timeout: duty_ready=%b expected 1 within 300 cycles", duty_ready);
        end
        @(posedge clk);
        #1;
        duty_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (period_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_done_timeout: period_done=%b expected 1 within 300 cycles", period_done);
        end
    endtask

    task automatic wait_slot(input logic [7:0] oh);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (Slot_OneHot === oh) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_slot_timeout: Slot_OneHot=%b expected %b within 300 cycles", Slot_OneHot, oh);
        end
    endtask

    // Starts at the current negedge; pattern MSB is the first sampled cycle.
    task automatic sample(input int n, output int highs, output logic [7:0] pat);
        highs = 0;
        pat   = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            highs += int'(Pwm_Out);
            if (i < 8) pat = {pat[6:0], Pwm_Out};
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         highs;
        logic [7:0] pat;
        int         r;

        reset = 1'b1; enable = 1'b0; Prescale = '0; Duty_In = '0; duty_valid = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_pwm",    32'(Pwm_Out),     32'd0);
        chk("rst_onehot", 32'(Slot_OneHot), 32'h01);
        chk("rst_ready",  32'(duty_ready),  32'd1);
        chk("rst_done",   32'(period_done), 32'd0);
        step(1);
        reset = 1'b0; enable = 1'b1;

        send_duty(3);
        wait_done(); wait_done();
        sample(8, highs, pat);
        chk("duty3_pattern", 32'(pat), 32'hE0);
        @(negedge clk);
        chk("done_every_8", 32'(period_done), 32'd1);

        step(1); send_duty(0);
        wait_done(); wait_done();
        sample(8, highs, pat);
        chk("duty0_highs", 32'(highs), 32'd0);

        step(1); send_duty(8);
        wait_done(); wait_done();
        sample(16, highs, pat);
        chk("duty8_highs", 32'(highs), 32'd16);

        step(1); send_duty(2);
        wait_done(); wait_done();
        step(1); send_duty(12);
        wait_done(); wait_done();
        sample(8, highs, pat);
        chk("clamp12_pattern", 32'(pat), 32'hFF);

        step(1); enable = 1'b0; Prescale = 16'd2;
        step(2); enable = 1'b1;
        send_duty(5);
        wait_done(); wait_done();
        highs = 0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            highs += int'(Pwm_Out);
            chk("presc2_slot", 32'(Slot_OneHot), 32'(1) << (i / 3));
        end
        chk("presc2_highs", 32'(highs), 32'd15);

        step(1); enable = 1'b0; Prescale = 16'd0;
        step(2); enable = 1'b1;
        send_duty(2);
        wait_done(); wait_done();
        wait_slot(8'b0000_1000);
        step(1);
        Duty_In = 4'd6; duty_valid = 1'b1;
        step(1);
        Duty_In = 4'd7;
        @(negedge clk);
        chk("held_ready_low", 32'(duty_ready), 32'd0);
        wait_done();
        chk("ready_after_bnd", 32'(duty_ready), 32'd1);
        sample(8, highs, pat);
        chk("duty6_pattern", 32'(pat), 32'hFC);
        step(1); duty_valid = 1'b0;

        wait_done();
        step(1); send_duty(4);
        wait_slot(8'b0010_0000);
        chk("pending_before_rst", 32'(duty_ready), 32'd0);
        reset = 1'b1;
        step(1); reset = 1'b0;
        @(negedge clk);
        chk("midrst_pwm",    32'(Pwm_Out),     32'd0);
        chk("midrst_onehot", 32'(Slot_OneHot), 32'h01);
        chk("midrst_ready",  32'(duty_ready),  32'd1);
        wait_done();
        sample(8, highs, pat);
        chk("midrst_active0", 32'(highs), 32'd0);

        step(1); enable = 1'b0;
        step(3);
        @(negedge clk);
        chk("dis_pwm",    32'(Pwm_Out),     32'd0);
        chk("dis_onehot", 32'(Slot_OneHot), 32'h01);
        step(1); send_duty(5);
        step(1); enable = 1'b1;
        wait_done();
        sample(8, highs, pat);
        chk("reenable_duty5", 32'(pat), 32'hF8);

        step(1);
        for (int c = 0; c < 1500; c++) begin
            r = int'($urandom_range(0, 99));
            reset = (r < 2);
            if (r >= 2 && r < 5) begin
                if (enable) begin
                    enable   = 1'b0;
                    Prescale = 16'($urandom_range(0, 3));
                end else begin
                    enable = 1'b1;
                end
            end
            duty_valid = ($urandom_range(0, 3) == 0);
            Duty_In    = 4'($urandom_range(0, 15));
            step(1);
        end
        reset = 1'b0; duty_valid = 1'b0;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
